// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared constants for the ALU arbiter slice: default widths, ALU function
//   codes, requester port ids and the result-slot state encoding.
package alu_arbiter_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int FUNC_SIZE_DEF = 11;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_XOR = 4;
    localparam int unsigned ALU_SLT = 5;

    localparam logic PORT_ISSUE = 1'b0;
    localparam logic PORT_BRU   = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu.sv
// alu
//   Single-cycle combinational ALU.
//   Ports:
//     i_a, i_b  [DATA_SIZE]  operands
//     i_func    [FUNC_SIZE]  operation code (ADD/SUB/AND/OR/XOR/SLT, others -> 0)
//     o_out     [DATA_SIZE]  result (ADD/SUB wrap, SLT is unsigned a<b)
//     o_zero                 o_out == 0
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int FUNC_SIZE = FUNC_SIZE_DEF
) (
    input  logic [DATA_SIZE-1:0] i_a,
    input  logic [DATA_SIZE-1:0] i_b,
    input  logic [FUNC_SIZE-1:0] i_func,
    output logic [DATA_SIZE-1:0] o_out,
    output logic                 o_zero
);

    always_comb begin
        o_out = '0;
        case (i_func)
            FUNC_SIZE'(ALU_ADD): o_out = i_a + i_b;
            FUNC_SIZE'(ALU_SUB): o_out = i_a - i_b;
            FUNC_SIZE'(ALU_AND): o_out = i_a & i_b;
            FUNC_SIZE'(ALU_OR):  o_out = i_a | i_b;
            FUNC_SIZE'(ALU_XOR): o_out = i_a ^ i_b;
            FUNC_SIZE'(ALU_SLT): o_out = DATA_SIZE'(i_a < i_b);
            default:             o_out = '0;
        endcase
    end

    assign o_zero = (o_out == '0);

endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick
//   Two-way grant logic. Default: round-robin, the port that did not win last
//   time wins a contest. With ALU_ARB_FIXED_PRIO_EN defined, port 0 always
//   wins a contest and i_last_id is ignored.
//   Ports:
//     i_valid0, i_valid1  request valids
//     i_last_id           id of the last accepted port
//     o_grant0, o_grant1  one-hot (or zero) grant
//     o_grant_id          id of the granted port (1 only when o_grant1)
module alu_rr_pick
    import alu_arbiter_pkg::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_id,
    output logic o_grant0,
    output logic o_grant1,
    output logic o_grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_id;
    assign unused_last_id = i_last_id;

    assign o_grant0 = i_valid0;
    assign o_grant1 = i_valid1 & ~i_valid0;
`else
    assign o_grant0 = i_valid0 & (~i_valid1 | (i_last_id == PORT_BRU));
    assign o_grant1 = i_valid1 & (~i_valid0 | (i_last_id == PORT_ISSUE));
`endif

    assign o_grant_id = o_grant1 ? PORT_BRU : PORT_ISSUE;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one ALU between the issue stage (port 0) and the address/branch
//   unit (port 1). Round-robin grant (fixed port-0 priority when
//   ALU_ARB_FIXED_PRIO_EN is defined), valid/ready on both sides, one-entry
//   registered result slot tagged with the requester id.
//   Ports:
//     i_clk, i_rst                 clock, async active-high reset
//     i_reqN_valid/_a/_b/_func     request per port (held until accepted)
//     o_reqN_ready                 accept this cycle when valid & ready
//     o_rsp_valid/_id/_out/_zero   registered result slot
//     i_rsp_ready                  consumer takes result when valid & ready
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int FUNC_SIZE = FUNC_SIZE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req0_valid,
    input  logic [DATA_SIZE-1:0] i_req0_a,
    input  logic [DATA_SIZE-1:0] i_req0_b,
    input  logic [FUNC_SIZE-1:0] i_req0_func,
    input  logic                 i_req1_valid,
    input  logic [DATA_SIZE-1:0] i_req1_a,
    input  logic [DATA_SIZE-1:0] i_req1_b,
    input  logic [FUNC_SIZE-1:0] i_req1_func,
    output logic                 o_req0_ready,
    output logic                 o_req1_ready,
    output logic                 o_rsp_valid,
    output logic                 o_rsp_id,
    output logic [DATA_SIZE-1:0] o_rsp_out,
    output logic                 o_rsp_zero,
    input  logic                 i_rsp_ready
);

    slot_state_e          state_q, state_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [DATA_SIZE-1:0] rsp_out_q, rsp_out_d;
    logic                 rsp_zero_q, rsp_zero_d;
    logic                 last_id_q, last_id_d;

    logic                 grant0, grant1, grant_id;
    logic                 can_accept, accept;
    logic [DATA_SIZE-1:0] alu_a, alu_b, alu_out;
    logic [FUNC_SIZE-1:0] alu_func;
    logic                 alu_zero;

    alu_rr_pick u_pick (
        .i_valid0   (i_req0_valid),
        .i_valid1   (i_req1_valid),
        .i_last_id  (last_id_q),
        .o_grant0   (grant0),
        .o_grant1   (grant1),
        .o_grant_id (grant_id)
    );

    assign alu_a    = grant_id ? i_req1_a    : i_req0_a;
    assign alu_b    = grant_id ? i_req1_b    : i_req0_b;
    assign alu_func = grant_id ? i_req1_func : i_req0_func;

    alu #(
        .DATA_SIZE (DATA_SIZE),
        .FUNC_SIZE (FUNC_SIZE)
    ) u_alu (
        .i_a    (alu_a),
        .i_b    (alu_b),
        .i_func (alu_func),
        .o_out  (alu_out),
        .o_zero (alu_zero)
    );

    // Reset clears the slot to EMPTY, so readies must be masked by i_rst
    // explicitly to stay low while reset is held.
    assign can_accept   = (state_q == SLOT_EMPTY) | i_rsp_ready;
    assign o_req0_ready = grant0 & can_accept & ~i_rst;
    assign o_req1_ready = grant1 & can_accept & ~i_rst;
    assign accept       = o_req0_ready | o_req1_ready;

    always_comb begin
        state_d    = state_q;
        rsp_id_d   = rsp_id_q;
        rsp_out_d  = rsp_out_q;
        rsp_zero_d = rsp_zero_q;
        last_id_d  = last_id_q;
        if (accept) begin
            state_d    = SLOT_FULL;
            rsp_id_d   = grant_id;
            rsp_out_d  = alu_out;
            rsp_zero_d = alu_zero;
            last_id_d  = grant_id;
        end else if ((state_q == SLOT_FULL) && i_rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= SLOT_EMPTY;
            rsp_id_q   <= 1'b0;
            rsp_out_q  <= '0;
            rsp_zero_q <= 1'b0;
            last_id_q  <= PORT_BRU;
        end else begin
            state_q    <= state_d;
            rsp_id_q   <= rsp_id_d;
            rsp_out_q  <= rsp_out_d;
            rsp_zero_q <= rsp_zero_d;
            last_id_q  <= last_id_d;
        end
    end

    assign o_rsp_valid = (state_q == SLOT_FULL);
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_out   = rsp_out_q;
    assign o_rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        r0v, r1v;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic [10:0] r0f, r1f;
    logic        rdy0, rdy1;
    logic        rsp_valid, rsp_id, rsp_zero;
    logic [31:0] rsp_out;
    logic        rsp_ready;

    int checks;
    int failures;

    alu_arbiter #(
        .DATA_SIZE (32),
        .FUNC_SIZE (11)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (r0v),
        .i_req0_a     (r0a),
        .i_req0_b     (r0b),
        .i_req0_func  (r0f),
        .i_req1_valid (r1v),
        .i_req1_a     (r1a),
        .i_req1_b     (r1b),
        .i_req1_func  (r1f),
        .o_req0_ready (rdy0),
        .o_req1_ready (rdy1),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_out    (rsp_out),
        .o_rsp_zero   (rsp_zero),
        .i_rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [10:0] f);
        r0v = v; r0a = a; r0b = b; r0f = f;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [10:0] f);
        r1v = v; r1a = a; r1b = b; r1f = f;
    endtask

    // Drives a lone port-0 request at posedge+1, checks it is accepted, and
    // returns at the next posedge+1 with the result in the slot.
    task automatic single_req0(input logic [31:0] a, input logic [31:0] b, input logic [10:0] f,
                               input string name, input logic [31:0] exp_out, input logic exp_zero);
        set_req0(1'b1, a, b, f);
        set_req1(1'b0, '0, '0, '0);
        #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b10) begin
            failures++;
            $display("FAIL %s_ready: got %b%b expected 10", name, rdy0, rdy1);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_out} !== {1'b1, 1'b0, exp_zero, exp_out}) begin
            failures++;
            $display("FAIL %s_rsp: got v=%b id=%b z=%b out=%h expected v=1 id=0 z=%b out=%h",
                     name, rsp_valid, rsp_id, rsp_zero, rsp_out, exp_zero, exp_out);
        end
        r0v = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req0(1'b1, 32'd1, 32'd2, 11'd0);
        set_req1(1'b1, 32'd1, 32'd2, 11'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_out} !== 35'd0) begin
            failures++;
            $display("FAIL reset_rsp: got v=%b id=%b z=%b out=%h expected all zero",
                     rsp_valid, rsp_id, rsp_zero, rsp_out);
        end
        checks++;
        if ({rdy0, rdy1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b%b expected 00", rdy0, rdy1);
        end
        r0v = 1'b0; r1v = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_ops();
        // ADD 3+4, then an idle cycle must drain the slot.
        single_req0(32'd3, 32'd4, 11'd0, "add", 32'd7, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: got v=%b expected 0", rsp_valid);
        end
        // Port 1 SUB 5-5.
        set_req1(1'b1, 32'd5, 32'd5, 11'd1);
        #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b01) begin
            failures++;
            $display("FAIL sub_ready: got %b%b expected 01", rdy0, rdy1);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_out} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL sub_rsp: got v=%b id=%b z=%b out=%h expected v=1 id=1 z=1 out=0",
                     rsp_valid, rsp_id, rsp_zero, rsp_out);
        end
        r1v = 1'b0;
        single_req0(32'd9, 32'd1, 11'd7, "badfunc", 32'd0, 1'b1);
        single_req0(32'd1, 32'hFFFF_FFFF, 11'd5, "slt_lt", 32'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic [10:0] tf [6];
        logic [31:0] te [6];
        ta = '{32'hFFFF_FFFF, 32'd0,         32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd5};
        tb = '{32'd1,         32'd1,         32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'd3};
        tf = '{11'd0,         11'd1,         11'd2,         11'd3,         11'd4,         11'd5};
        te = '{32'd0,         32'hFFFF_FFFF, 32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'd0};
        set_req1(1'b0, '0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            set_req0(1'b1, ta[i], tb[i], tf[i]);
            #1;
            checks++;
            if (rdy0 !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rdy0);
            end
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_out} !== {1'b1, 1'b0, (te[i] == 32'd0), te[i]}) begin
                failures++;
                $display("FAIL b2b_rsp[%0d]: got v=%b id=%b z=%b out=%h expected out=%h",
                         i, rsp_valid, rsp_id, rsp_zero, rsp_out, te[i]);
            end
        end
        r0v = 1'b0;
        @(posedge clk); #1;
    endtask

    // Entered with last accepted port = 0 (port 0 issued the last op).
    task automatic test_round_robin();
        logic exp;
        set_req0(1'b1, 32'd10, 32'd1, 11'd0);
        set_req1(1'b1, 32'd20, 32'd2, 11'd0);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp = 1'b0;
`else
            exp = (i % 2 == 0);
`endif
            #1;
            checks++;
            if ({rdy0, rdy1} !== {~exp, exp}) begin
                failures++;
                $display("FAIL rr_ready[%0d]: got %b%b expected %b%b", i, rdy0, rdy1, ~exp, exp);
            end
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, exp, (exp ? 32'd22 : 32'd11)}) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%b out=%0d expected id=%b out=%0d",
                         i, rsp_valid, rsp_id, rsp_out, exp, exp ? 22 : 11);
            end
        end
        r0v = 1'b0; r1v = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic exp;
        single_req0(32'd3, 32'd4, 11'd0, "stall_fill", 32'd7, 1'b0);
        rsp_ready = 1'b0;
        set_req0(1'b1, 32'd10, 32'd1, 11'd0);
        set_req1(1'b1, 32'd20, 32'd2, 11'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rdy0, rdy1} !== 2'b00) begin
                failures++;
                $display("FAIL stall_ready[%0d]: got %b%b expected 00", i, rdy0, rdy1);
            end
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_zero, rsp_out} !== {1'b1, 1'b0, 1'b0, 32'd7}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%b z=%b out=%h expected v=1 id=0 z=0 out=7",
                         i, rsp_valid, rsp_id, rsp_zero, rsp_out);
            end
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp = 1'b0;
`else
        exp = 1'b1;
`endif
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rdy0, rdy1} !== {~exp, exp}) begin
            failures++;
            $display("FAIL unstall_ready: got %b%b expected %b%b", rdy0, rdy1, ~exp, exp);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, exp, (exp ? 32'd22 : 32'd11)}) begin
            failures++;
            $display("FAIL unstall_rsp: got v=%b id=%b out=%0d expected id=%b out=%0d",
                     rsp_valid, rsp_id, rsp_out, exp, exp ? 22 : 11);
        end
        r0v = 1'b0; r1v = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_full();
        single_req0(32'd3, 32'd4, 11'd0, "rstfull_fill", 32'd7, 1'b0);
        rsp_ready = 1'b0;
        set_req0(1'b1, 32'd10, 32'd1, 11'd0);
        set_req1(1'b1, 32'd20, 32'd2, 11'd0);
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero, rsp_out} !== 35'd0) begin
            failures++;
            $display("FAIL async_reset_rsp: got v=%b id=%b z=%b out=%h expected all zero",
                     rsp_valid, rsp_id, rsp_zero, rsp_out);
        end
        checks++;
        if ({rdy0, rdy1} !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_ready: got %b%b expected 00", rdy0, rdy1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b10) begin
            failures++;
            $display("FAIL post_reset_ready: got %b%b expected 10", rdy0, rdy1);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 1'b0, 32'd11}) begin
            failures++;
            $display("FAIL post_reset_rsp: got v=%b id=%b out=%0d expected v=1 id=0 out=11",
                     rsp_valid, rsp_id, rsp_out);
        end
        r0v = 1'b0; r1v = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_ops();
        test_back_to_back();
        test_round_robin();
        test_stall();
        test_reset_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
